// File: rtl/rv32_pkg.sv
// Shared RV32 M-extension op codes and multiply/divide FSM state encoding,
// used by both the control unit and muldiv_unit.
package rv32_pkg;

  typedef enum logic [4:0] {
    OP_MUL    = 5'b00001,
    OP_MULH   = 5'b00101,
    OP_MULHSU = 5'b01101,
    OP_MULHU  = 5'b01001,
    OP_DIV    = 5'b10001,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b11001,
    OP_REMU   = 5'b11101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

  function automatic logic is_mul_op(input logic [4:0] code);
    return (code == OP_MUL) || (code == OP_MULH) || (code == OP_MULHSU) || (code == OP_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] code);
    return (code == OP_DIV) || (code == OP_DIVU) || (code == OP_REM) || (code == OP_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [4:0] code);
    return (code == OP_DIV) || (code == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] code);
    return (code == OP_REM) || (code == OP_REMU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per step,
// 32 steps after load; the iteration counter saturates at 31.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  logic [5:0]      cnt;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN:0]   partial, diff;
  logic            take;

  // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  always_comb begin
    partial = {rem_q, quo_q[XLEN-1]};
    diff    = partial - {1'b0, dvs_q};
    take    = ~diff[XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= take ? diff[XLEN-1:0] : partial[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], take};
      if (cnt != 6'(XLEN - 1)) cnt <= cnt + 6'd1;
    end
  end

  assign last      = (cnt == 6'(XLEN - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32 M-extension execute unit: 2-edge multiplier, 34-edge iterative divider,
// 2-edge fast paths for divide-by-zero and signed overflow; flushable.
module muldiv_unit
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state, state_next;
  logic            accept, div_load, div_step, finish, last;
  logic            sdiv_in, fast_in;
  logic [XLEN-1:0] dividend_mag, divisor_mag, quo, rem;
  logic [4:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            fast_q, neg_quo, neg_rem;
  logic [XLEN:0]   a_ext, b_ext;
  logic [2*XLEN-1:0] a_wide, b_wide, product;
  logic [XLEN-1:0] mul_res, quo_fix, rem_fix, fast_res, div_res;

  always_comb begin
    sdiv_in      = is_signed_div(op);
    fast_in      = (b == '0) || (sdiv_in && (a == MIN_INT) && (b == '1));
    dividend_mag = (sdiv_in && a[XLEN-1]) ? -a : a;
    divisor_mag  = (sdiv_in && b[XLEN-1]) ? -b : b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Fast-path divides skip straight to FIX so they share the multiplier's latency.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    div_load   = 1'b0;
    div_step   = 1'b0;
    finish     = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && is_mul_op(op)) begin
            accept     = 1'b1;
            state_next = MUL;
          end else if (start && is_div_op(op)) begin
            accept     = 1'b1;
            div_load   = 1'b1;
            state_next = fast_in ? FIX : DIV;
          end
        end
        MUL: begin
          finish     = 1'b1;
          state_next = IDLE;
        end
        DIV: begin
          div_step = 1'b1;
          if (last) state_next = FIX;
        end
        FIX: begin
          finish     = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (dividend_mag),
    .divisor   (divisor_mag),
    .quotient  (quo),
    .remainder (rem),
    .last      (last)
  );

  // 33x33 signed product, computed in 64 bits via explicit sign extension.
  always_comb begin
    a_ext   = {((op_q == OP_MULH) || (op_q == OP_MULHSU)) & a_q[XLEN-1], a_q};
    b_ext   = {(op_q == OP_MULH) & b_q[XLEN-1], b_q};
    a_wide  = {{(XLEN-1){a_ext[XLEN]}}, a_ext};
    b_wide  = {{(XLEN-1){b_ext[XLEN]}}, b_ext};
    product = a_wide * b_wide;
    mul_res = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  always_comb begin
    quo_fix = neg_quo ? -quo : quo;
    rem_fix = neg_rem ? -rem : rem;
    if (is_rem_op(op_q)) fast_res = (b_q == '0) ? a_q : '0;
    else                 fast_res = (b_q == '0) ? '1 : MIN_INT;
    if (fast_q)                 div_res = fast_res;
    else if (is_rem_op(op_q))   div_res = rem_fix;
    else                        div_res = quo_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fast_q  <= 1'b0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      if (accept) begin
        op_q    <= op;
        a_q     <= a;
        b_q     <= b;
        fast_q  <= fast_in;
        neg_quo <= sdiv_in & (a[XLEN-1] ^ b[XLEN-1]);
        neg_rem <= sdiv_in & a[XLEN-1];
      end
      done <= finish;
      if (finish) result <= (state == MUL) ? mul_res : div_res;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with per-cycle compare of
// busy/done/result, plus directed vectors carrying hand-computed results/latencies.
module tb_muldiv_unit;

  localparam logic [4:0] C_MUL = 5'b00001, C_MULH = 5'b00101, C_MULHSU = 5'b01101, C_MULHU = 5'b01001;
  localparam logic [4:0] C_DIV = 5'b10001, C_DIVU = 5'b10101, C_REM = 5'b11001, C_REMU = 5'b11101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Model state: busy while busy_from <= cyc < busy_until; done at cyc == done_at.
  int          busy_from = 0, busy_until = -1, done_at = -1;
  logic [31:0] res_now = '0, res_next = '0;
  int          last_done_cyc = -1;
  int          done_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    int          sx, sy;
    longint      sp;
    logic [63:0] up;
    logic        ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      C_MUL:    begin sp = longint'(sx) * longint'(sy); return sp[31:0]; end
      C_MULH:   begin sp = longint'(sx) * longint'(sy); return sp[63:32]; end
      C_MULHSU: begin sp = longint'(sx) * longint'({32'h0, y}); return sp[63:32]; end
      C_MULHU:  begin up = {32'h0, x} * {32'h0, y}; return up[63:32]; end
      C_DIV:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
      C_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      C_REM:    return (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy);
      C_REMU:   return (y == 0) ? x : x % y;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o == C_MUL || o == C_MULH || o == C_MULHSU || o == C_MULHU) return 2;
    if (y == 0) return 2;
    if ((o == C_DIV || o == C_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (cyc == done_at) res_now = res_next;
      chk("busy", {31'b0, busy}, {31'b0, (cyc >= busy_from) && (cyc < busy_until)});
      chk("done", {31'b0, done}, {31'b0, cyc == done_at});
      chk("result", result, res_now);
      if (done) begin
        last_done_cyc = cyc;
        done_total++;
      end
    end
  end

  // Called at a negedge; drives start for one cycle and returns at the next negedge.
  task automatic op_begin(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, output int e);
    int lat;
    start = 1'b1; op = o; a = x; b = y;
    e = cyc + 1;
    lat = model_lat(o, x, y);
    busy_from  = e;
    busy_until = e + lat - 1;
    done_at    = e + lat - 1;
    res_next   = model_res(o, x, y);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic op_run(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, output int e);
    op_begin(o, x, y, e);
    while (cyc < done_at) @(negedge clk);
  endtask

  typedef struct {
    logic [4:0]  o;
    logic [31:0] x, y, e;
    int          l;
  } vec_t;

  vec_t vecs [0:19];

  initial begin
    int e, dt;
    vecs = '{
      '{C_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2},
      '{C_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2},
      '{C_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 2},
      '{C_MULH,   32'hFFFF_FFFB,  32'd3,         32'hFFFF_FFFF, 2},
      '{C_MULH,   32'h4000_0000,  32'd4,         32'h0000_0001, 2},
      '{C_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2},
      '{C_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 34},
      '{C_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 34},
      '{C_DIVU,   32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 2},
      '{C_REMU,   32'h1234_5678,  32'd0,         32'h1234_5678, 2},
      '{C_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2},
      '{C_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 2},
      '{C_DIVU,   32'd100,        32'd7,         32'd14,        34},
      '{C_REMU,   32'd100,        32'd7,         32'd2,         34},
      '{C_REM,    32'd20,         32'hFFFF_FFFD, 32'd2,         34},
      '{C_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34},
      '{C_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34},
      '{C_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 2},
      '{C_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 34},
      '{C_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34}
    };

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vectors run back to back: each start is issued in the previous done cycle.
    for (int i = 0; i < 20; i++) begin
      op_run(vecs[i].o, vecs[i].x, vecs[i].y, e);
      chk($sformatf("vec%0d_result", i), result, vecs[i].e);
      chk($sformatf("vec%0d_latency", i), 32'(last_done_cyc - e + 1), 32'(vecs[i].l));
    end

    // Flush a DIVU at iteration 10, then start a new op the following cycle.
    op_begin(C_DIVU, 32'hFFFF_FFF0, 32'd3, e);
    while (cyc < e + 9) @(negedge clk);
    flush = 1'b1;
    busy_until = cyc + 1;
    done_at = -1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_result_kept", result, 32'h8000_0000);
    op_run(C_DIVU, 32'd100, 32'd7, e);
    chk("after_flush_result", result, 32'd14);

    // Flush with a simultaneous start in IDLE, then an invalid op: both ignored.
    dt = done_total;
    start = 1'b1; flush = 1'b1; op = C_MUL; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'b0, busy}, 32'd0);
    start = 1'b1; op = 5'b00011;
    @(negedge clk);
    start = 1'b0;
    chk("bad_op_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("ignored_no_done", 32'(done_total - dt), 32'd0);
    chk("ignored_result", result, 32'd14);

    // Asynchronous reset in the middle of a DIV.
    op_begin(C_DIV, 32'hFFFF_FFEC, 32'd3, e);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    busy_until = -1;
    done_at = -1;
    res_now = '0;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_done", {31'b0, done}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dt = done_total;
    repeat (40) @(negedge clk);
    chk("rst_no_done", 32'(done_total - dt), 32'd0);

    op_run(C_MUL, 32'd7, 32'hFFFF_FFFD, e);
    chk("post_rst_mul", result, 32'hFFFF_FFEB);
    chk("post_rst_latency", 32'(last_done_cyc - e + 1), 32'd2);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
